// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse_meter tick-period measurement block.
package pulse_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pm_state_e;

    localparam int PM_W_DEFAULT = 8;

    // Largest value a w-bit period counter can hold before it saturates.
    function automatic int unsigned pm_sat(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_meter_edge.sv
// Tick rising-edge detector; with PULSE_METER_SYNC_EN defined the tick first
// passes a 2-flop synchronizer, adding two cycles of latency.
module pulse_meter_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    output logic o_rise
);

    logic w_tick_s;
    logic r_tick_q;

`ifdef PULSE_METER_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= 2'b00;
        else      r_sync <= {r_sync[0], i_tick};
    end

    assign w_tick_s = r_sync[1];
`else
    assign w_tick_s = i_tick;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tick_q <= 1'b0;
        else      r_tick_q <= w_tick_s;
    end

    // A level held high for many cycles yields a single event.
    assign o_rise = w_tick_s & ~r_tick_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures clk cycles between consecutive tick rising edges and offers each
// period on a valid/ready port. Optional macro: PULSE_METER_SYNC_EN.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int W = PM_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         tick,
    output logic [W-1:0] period,
    output logic         period_valid,
    input  logic         period_ready,
    output logic         overflow,
    output logic         lost
);

    localparam logic [W-1:0] SAT = W'(pm_sat(W));

    pm_state_e    r_state, w_state_nxt;
    logic [W-1:0] r_count, w_count_nxt;
    logic         r_sat, w_sat_nxt;
    logic         w_rise;
    logic         w_capture;

    logic [W-1:0] r_period;
    logic         r_valid;
    logic         r_ovf;
    logic         r_lost;

    pulse_meter_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_tick (tick),
        .o_rise (w_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_sat_nxt   = r_sat;
        w_capture   = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_sat_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = MEASURE;
                        w_count_nxt = W'(1);
                        w_sat_nxt   = 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        w_capture   = 1'b1;
                        w_count_nxt = W'(1);
                        w_sat_nxt   = 1'b0;
                    // Holding at SAT for one more cycle means the interval exceeds SAT.
                    end else if (r_count == SAT) begin
                        w_sat_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = r_count + W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    w_sat_nxt   = 1'b0;
                end
            endcase
        end
    end

    // A capture into a free slot (or one being consumed this cycle) wins;
    // otherwise the new result is dropped and flagged on lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_lost <= 1'b0;
            if (w_capture) begin
                if (!r_valid || period_ready) begin
                    r_period <= r_count;
                    r_ovf    <= r_sat;
                    r_valid  <= 1'b1;
                end else begin
                    r_lost   <= 1'b1;
                end
            end else if (r_valid && period_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign overflow     = r_ovf;
    assign lost         = r_lost;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench: W=4 and W=8 instances share stimulus and are compared
// against an edge-timestamp reference model.
module tb_pulse_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tick;
    logic       period_ready;
    logic [3:0] p4;
    logic [7:0] p8;
    logic       v4, v8, o4, o8, l4, l8;

    int checks = 0;
    int errors = 0;

    // reference model state
    int cyc = 0;
    int last_edge = 0;
    bit armed = 0;
    bit prev_t = 0;
    bit mv = 0;
    int miv = 0;
    bit mlost = 0;
    bit [1:0] dly = 2'b00;

    always #5 clk = ~clk;

    pulse_meter #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .period(p4), .period_valid(v4), .period_ready(period_ready),
        .overflow(o4), .lost(l4)
    );

    pulse_meter #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .period(p8), .period_valid(v8), .period_ready(period_ready),
        .overflow(o8), .lost(l8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_outputs();
        chk("valid4", 32'(v4), 32'(mv));
        chk("valid8", 32'(v8), 32'(mv));
        chk("lost4", 32'(l4), 32'(mlost));
        chk("lost8", 32'(l8), 32'(mlost));
        if (mv) begin
            chk("period4", 32'(p4), (miv > 15) ? 32'd15 : 32'(miv));
            chk("ovf4", 32'(o4), 32'(miv > 15));
            chk("period8", 32'(p8), (miv > 255) ? 32'd255 : 32'(miv));
            chk("ovf8", 32'(o8), 32'(miv > 255));
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, check.
    task automatic cycle(input bit t, input bit e, input bit r);
        bit ts, rise, cap;
        int iv;
        tick = t; en = e; period_ready = r;
        @(posedge clk);
`ifdef PULSE_METER_SYNC_EN
        ts  = dly[1];
        dly = {dly[0], t};
`else
        ts  = t;
`endif
        rise   = ts && !prev_t;
        prev_t = ts;
        cap    = 0;
        iv     = 0;
        if (!e) armed = 0;
        else if (rise) begin
            if (armed) begin
                cap = 1;
                iv  = cyc - last_edge;
            end
            armed     = 1;
            last_edge = cyc;
        end
        mlost = 0;
        if (cap) begin
            if (!mv || r) begin
                mv  = 1;
                miv = iv;
            end else mlost = 1;
        end else if (mv && r) mv = 0;
        cyc++;
        #1;
        chk_outputs();
    endtask

    // n edges, gap cycles apart, tick high for hi cycles of each gap.
    task automatic pulses(input int gap, input int hi, input int n, input bit r);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < gap; j++)
                cycle(j < hi, 1'b1, r);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_valid", 32'(v4 | v8), 32'd0);
        chk("rst_period", 32'(p4) + 32'(p8), 32'd0);
        chk("rst_ovf", 32'(o4 | o8), 32'd0);
        chk("rst_lost", 32'(l4 | l8), 32'd0);
        armed = 0; prev_t = 0; mv = 0; mlost = 0; dly = 2'b00;
        #1 rst = 1'b1;
    endtask

    initial begin
        int g, hl;
        rst = 1'b0; en = 1'b0; tick = 1'b0; period_ready = 1'b0;
        #2;
        chk("init_valid", 32'(v4 | v8), 32'd0);
        chk("init_period", 32'(p4) + 32'(p8), 32'd0);
        chk("init_flags", 32'(o4 | o8 | l4 | l8), 32'd0);
        #1 rst = 1'b1;

        // steady 5-cycle tick, always ready
        pulses(5, 1, 6, 1'b1);
        // long gaps saturate W=4, short gaps do not
        pulses(20, 1, 3, 1'b1);
        pulses(3, 1, 3, 1'b1);
        // back-pressure: first result held, later ones dropped
        pulses(4, 1, 4, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        // consume and capture in the same cycle
        pulses(4, 1, 2, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("same_cycle_period", 32'(p4), 32'd6);
        chk("same_cycle_lost", 32'(l4), 32'd0);
        cycle(1'b0, 1'b1, 1'b1);
        // async reset while a result is pending and a measurement is running
        pulses(5, 1, 2, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        do_reset();
        cycle(1'b0, 1'b1, 1'b1);
        pulses(7, 1, 3, 1'b1);
        // wide high level, then en dropped mid-interval
        pulses(12, 10, 3, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 2; j++) cycle(1'b0, 1'b1, 1'b1);
        pulses(5, 1, 3, 1'b1);

        // randomized gaps, enables and back-pressure
        for (int k = 0; k < 200; k++) begin
            g  = ($urandom_range(0, 9) == 0) ? $urandom_range(240, 300) : $urandom_range(2, 30);
            hl = $urandom_range(1, g - 1);
            for (int j = 0; j < g; j++)
                cycle(j < hl, $urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
